// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter and sequencer for the single-port data memory.
// Each granted access takes IDLE/RESP -> ACCESS -> RESP; the ack pulses in RESP.
module dm_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BYTE_SPAN = 12
) (
  input  logic              CLK_I,
  input  logic              RESET_I,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [31:0]       M0_ADDR,
  input  logic [31:0]       M0_WDATA,
  output logic              M0_ACK,
  output logic              M0_ERR,
  output logic [31:0]       M0_RDATA,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [31:0]       M1_ADDR,
  input  logic [31:0]       M1_WDATA,
  output logic              M1_ACK,
  output logic              M1_ERR,
  output logic [31:0]       M1_RDATA,
  output logic [ADDR_W-1:0] DM_ADDR,
  output logic [31:0]       DM_WDATA,
  output logic              DM_WE,
  input  logic [31:0]       DM_RDATA,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        last_grant;
  logic        cur;
  logic        lat_err;

  logic        cand0;
  logic        cand1;
  logic        do_latch;
  logic        grant;
  logic        sel_we;
  logic        sel_err;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> BYTE_SPAN) != 32'd0);
  endfunction

  // State register
  always_ff @(posedge CLK_I) begin
    if (!RESET_I) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = do_latch ? ACCESS : IDLE;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = do_latch ? ACCESS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Arbitration; in RESP the acked master still shows its old request and is masked.
  always_comb begin
    cand0 = M0_REQ;
    cand1 = M1_REQ;
    if (state == RESP) begin
      if (cur) cand1 = 1'b0;
      else     cand0 = 1'b0;
    end
    do_latch = (state != ACCESS) && (cand0 || cand1);
    if (cand0 && cand1) grant = ~last_grant;
    else                grant = cand1;
    sel_we    = grant ? M1_WE    : M0_WE;
    sel_addr  = grant ? M1_ADDR  : M0_ADDR;
    sel_wdata = grant ? M1_WDATA : M0_WDATA;
    sel_err   = addr_err(sel_addr);
  end

  assign BUSY = (state != IDLE);

  // Registered datapath: latch on grant, capture read word and pulse ack leaving ACCESS.
  always_ff @(posedge CLK_I) begin
    if (!RESET_I) begin
      last_grant <= 1'b1;
      cur        <= 1'b0;
      lat_err    <= 1'b0;
      DM_ADDR    <= '0;
      DM_WDATA   <= '0;
      DM_WE      <= 1'b0;
      M0_ACK     <= 1'b0;
      M0_ERR     <= 1'b0;
      M0_RDATA   <= '0;
      M1_ACK     <= 1'b0;
      M1_ERR     <= 1'b0;
      M1_RDATA   <= '0;
    end else begin
      M0_ACK <= 1'b0;
      M0_ERR <= 1'b0;
      M1_ACK <= 1'b0;
      M1_ERR <= 1'b0;
      DM_WE  <= 1'b0;
      if (do_latch) begin
        cur        <= grant;
        last_grant <= grant;
        lat_err    <= sel_err;
        DM_ADDR    <= sel_addr[ADDR_W+1:2];
        DM_WDATA   <= sel_wdata;
        DM_WE      <= sel_we && !sel_err;
      end
      if (state == ACCESS) begin
        if (cur) begin
          M1_ACK   <= 1'b1;
          M1_ERR   <= lat_err;
          M1_RDATA <= lat_err ? '0 : DM_RDATA;
        end else begin
          M0_ACK   <= 1'b1;
          M0_ERR   <= lat_err;
          M0_RDATA <= lat_err ? '0 : DM_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: table of single accesses plus reset,
// contention, back-to-back and reset-during-access sequences.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_mem = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];

  logic        ack0, ack1, err0, err1, dm_we, busy;
  logic [31:0] rd0, rd1, dm_wdata, dm_rdata;
  logic [9:0]  dm_addr;

  logic [31:0] mem [1024];
  logic [31:0] exp_rd [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(10), .BYTE_SPAN(12)) dut (
    .CLK_I(clk), .RESET_I(rst_n),
    .M0_REQ(req[0]), .M0_WE(we[0]), .M0_ADDR(addr[0]), .M0_WDATA(wdata[0]),
    .M0_ACK(ack0), .M0_ERR(err0), .M0_RDATA(rd0),
    .M1_REQ(req[1]), .M1_WE(we[1]), .M1_ADDR(addr[1]), .M1_WDATA(wdata[1]),
    .M1_ACK(ack1), .M1_ERR(err1), .M1_RDATA(rd1),
    .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata), .DM_WE(dm_we), .DM_RDATA(dm_rdata),
    .BUSY(busy)
  );

  assign dm_rdata = mem[dm_addr];

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
    end
  end

  typedef struct {
    int          m;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(int m);
    return (m == 1) ? ack1 : ack0;
  endfunction

  function automatic logic err_of(int m);
    return (m == 1) ? err1 : err0;
  endfunction

  function automatic logic [31:0] rd_of(int m);
    return (m == 1) ? rd1 : rd0;
  endfunction

  function automatic logic [31:0] item_addr(int m, int j);
    return 32'h100 + 32'(m) * 32'h40 + 32'(j) * 32'd4;
  endfunction

  function automatic logic [31:0] item_data(int m, int j);
    return 32'hC0DE0000 + 32'(m) * 32'h100 + 32'(j);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int o;
    o = 1 - v.m;
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    req[v.m]   = 1'b1;
    we[v.m]    = v.w;
    addr[v.m]  = v.a;
    wdata[v.m] = v.d;
    tick();
    chk($sformatf("v%0d_acc_busy", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d_acc_addr", idx), 32'(dm_addr), 32'(v.a[11:2]));
    chk($sformatf("v%0d_acc_we", idx), 32'(dm_we), 32'(v.w && !v.e));
    if (v.w && !v.e) chk($sformatf("v%0d_acc_wdata", idx), dm_wdata, v.d);
    tick();
    exp_rd[v.m] = v.rd;
    chk($sformatf("v%0d_ack", idx), 32'(ack_of(v.m)), 32'd1);
    chk($sformatf("v%0d_err", idx), 32'(err_of(v.m)), 32'(v.e));
    chk($sformatf("v%0d_rdata", idx), rd_of(v.m), exp_rd[v.m]);
    chk($sformatf("v%0d_other_ack", idx), 32'(ack_of(o)), 32'd0);
    chk($sformatf("v%0d_other_rdata", idx), rd_of(o), exp_rd[o]);
    chk($sformatf("v%0d_resp_we", idx), 32'(dm_we), 32'd0);
    tick();
    req[v.m] = 1'b0;
    chk($sformatf("v%0d_ack_drop", idx), 32'(ack_of(v.m)), 32'd0);
    chk($sformatf("v%0d_end_busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m, p, j, jp;
    vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1, 1'b1, 32'h0000_1000, 32'h12345678, 1'b1, 32'h0};
    vecs[3]  = '{1, 1'b0, 32'h0000_1010, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h0000_0002, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1, 1'b1, 32'h0000_0FFC, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[6]  = '{0, 1'b0, 32'h0000_0FFC, 32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[7]  = '{1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[8]  = '{0, 1'b1, 32'h8000_0010, 32'h11111111, 1'b1, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[10] = '{1, 1'b0, 32'h0000_0104, 32'h0,        1'b0, 32'hC0DE0001};
    vecs[11] = '{0, 1'b0, 32'h0000_0148, 32'h0,        1'b0, 32'hC0DE0102};
    vecs[12] = '{1, 1'b1, 32'h0000_0013, 32'h22222222, 1'b1, 32'h0};
    vecs[13] = '{1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[14] = '{0, 1'b1, 32'h0000_0010, 32'h55AA55AA, 1'b0, 32'hDEADBEEF};

    // Reset with both masters requesting
    for (int i = 0; i < 2; i++) begin
      req[i]   = 1'b1;
      we[i]    = 1'b1;
      addr[i]  = item_addr(i, 0);
      wdata[i] = item_data(i, 0);
    end
    tick();
    clear_mem = 1'b0;
    tick();
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Continuous contention: grants alternate M0, M1, ... with no idle cycle
    for (int k = 0; k < 6; k++) begin
      m = k % 2;
      j = k / 2;
      tick();
      chk($sformatf("cont%0d_busy", k), 32'(busy), 32'd1);
      chk($sformatf("cont%0d_addr", k), 32'(dm_addr), item_addr(m, j) >> 2);
      chk($sformatf("cont%0d_we", k), 32'(dm_we), 32'd1);
      chk($sformatf("cont%0d_wdata", k), dm_wdata, item_data(m, j));
      chk($sformatf("cont%0d_noack", k), 32'({ack1, ack0}), 32'd0);
      if (k > 0) begin
        p  = 1 - m;
        jp = (k - 1) / 2 + 1;
        if (jp < 3) begin
          addr[p]  = item_addr(p, jp);
          wdata[p] = item_data(p, jp);
        end else begin
          req[p] = 1'b0;
        end
      end
      tick();
      chk($sformatf("cont%0d_ack", k), 32'(ack_of(m)), 32'd1);
      chk($sformatf("cont%0d_other_ack", k), 32'(ack_of(1 - m)), 32'd0);
      chk($sformatf("cont%0d_err", k), 32'(err_of(m)), 32'd0);
      chk($sformatf("cont%0d_rdata", k), rd_of(m), 32'd0);
    end
    tick();
    req[1] = 1'b0;
    chk("cont_end_busy", 32'(busy), 32'd0);
    chk("cont_end_ack1", 32'(ack1), 32'd0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // M1 request rising during M0's ack cycle is granted back-to-back
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    tick();
    chk("b2b_m0_addr", 32'(dm_addr), 32'd4);
    tick();
    chk("b2b_m0_ack", 32'(ack0), 32'd1);
    chk("b2b_m0_rdata", rd0, 32'h55AA55AA);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h104;
    tick();
    chk("b2b_m1_busy", 32'(busy), 32'd1);
    chk("b2b_m1_addr", 32'(dm_addr), 32'h41);
    chk("b2b_m1_noack", 32'({ack1, ack0}), 32'd0);
    req[0] = 1'b0;
    tick();
    chk("b2b_m1_ack", 32'(ack1), 32'd1);
    chk("b2b_m1_rdata", rd1, 32'hC0DE0001);
    chk("b2b_m0_noack", 32'(ack0), 32'd0);
    tick();
    req[1] = 1'b0;
    chk("b2b_end_busy", 32'(busy), 32'd0);
    chk("b2b_end_ack", 32'({ack1, ack0}), 32'd0);

    // Reset during a write ACCESS aborts it and restores M0 priority
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h77777777;
    tick();
    chk("rsta_we_before", 32'(dm_we), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rsta_we", 32'(dm_we), 32'd0);
    chk("rsta_busy", 32'(busy), 32'd0);
    chk("rsta_ack", 32'({ack1, ack0}), 32'd0);
    chk("rsta_rd0", rd0, 32'd0);
    we[0] = 1'b0; addr[0] = 32'h10;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h104;
    rst_n = 1'b1;
    tick();
    chk("rsta_grant_m0", 32'(dm_addr), 32'd4);
    chk("rsta_noack", 32'({ack1, ack0}), 32'd0);
    tick();
    chk("rsta_m0_ack", 32'(ack0), 32'd1);
    chk("rsta_m0_rdata", rd0, 32'h55AA55AA);
    req[0] = 1'b0;
    tick();
    chk("rsta_m1_addr", 32'(dm_addr), 32'h41);
    tick();
    chk("rsta_m1_ack", 32'(ack1), 32'd1);
    chk("rsta_m1_rdata", rd1, 32'hC0DE0001);
    tick();
    req[1] = 1'b0;
    chk("rsta_end_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port 4 KB data memory.
- Master 0 is the CPU data port; master 1 is the loader/DMA port.
- Grants one access at a time using round-robin.
- Drives registered address, write data and write-enable to the memory, and returns a registered read word with a one-cycle ack pulse.
- Sits between the core's data-memory outputs and the data memory instance in the top level.

Parameters:
- ADDR_W, 10, word-address width driven to memory (1024 words = 4 KB).
- BYTE_SPAN, 12, byte-address bits that are in range; addr[31:BYTE_SPAN] must be zero.

Ports:
- CLK_I  input  1  system clock, all state on rising edge.
- RESET_I  input  1  reset; synchronous, active-low.
- M0_REQ  input  1  CPU request; held high with WE/ADDR/WDATA stable until M0_ACK.
- M0_WE  input  1  CPU write (1) / read (0).
- M0_ADDR  input  32  CPU byte address.
- M0_WDATA  input  32  CPU write data.
- M0_ACK  output  1  one-cycle completion pulse to CPU.
- M0_ERR  output  1  valid with M0_ACK; access rejected.
- M0_RDATA  output  32  read word, valid with M0_ACK.
- M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_ACK, M1_ERR, M1_RDATA: identical set for master 1.
- DM_ADDR  output  ADDR_W  word address to memory (byte addr[ADDR_W+1:2]).
- DM_WDATA  output  32  write data to memory.
- DM_WE  output  1  memory write enable.
- DM_RDATA  input  32  memory combinational read data.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (RESET_I=0 at a rising edge) forces:
  - state=IDLE; all outputs 0 (ACKs, ERRs, RDATAs, DM_ADDR, DM_WDATA, DM_WE, BUSY).
  - last_grant=1, so M0 wins the first tie.
- Reset mid-access aborts: no ack is issued, and DM_WE is 0 from the next cycle.
- States and transitions:
  - IDLE: if any REQ is high, pick a winner, latch its WE/ADDR/WDATA and compute err; go to ACCESS. Otherwise stay.
  - ACCESS: drive the latched DM_ADDR/DM_WDATA; DM_WE=latched WE and not err. Capture DM_RDATA (0 if err) into the winner's RDATA at the edge. Go to RESP.
  - RESP: the winner's ACK=1 and ERR=err for exactly this cycle. Arbitrate among the requesters, excluding the master being acked (its REQ is still the old request). If the other master requests, latch it and go to ACCESS; else go to IDLE.
- Arbitration:
  - Round-robin: on conflict, grant the master not equal to last_grant.
  - last_grant updates on every latch.
  - A single requester always wins.
- Latency and throughput:
  - REQ seen in IDLE at cycle t: ACCESS at t+1, ACK at t+2.
  - Maximum throughput is one access per 2 cycles.
  - Two continuously requesting masters strictly alternate.
- Handshake:
  - A master must hold its request stable until ACK.
  - It may deassert REQ or present a new request in the cycle after ACK; that request is sampled from then on.
  - The arbiter ignores changes to unlatched inputs.
- Error condition: addr[1:0]!=0 or addr[31:BYTE_SPAN]!=0.
  - Erroring writes never assert DM_WE.
  - Erroring reads return RDATA=0.
  - Latency is identical to a normal access.
- Output hold rules:
  - A master's RDATA holds its value until that master's next ACK.
  - DM_ADDR/DM_WDATA hold their last latched value outside ACCESS.
  - DM_WE is high only in ACCESS.
- Simultaneous events: REQ rising in the RESP cycle on the non-acked master is granted back-to-back with no idle cycle.

Test Plan:
- Reset: hold RESET_I=0 two cycles with both REQs high -> all outputs 0, BUSY=0. Release: M0 granted first (ACCESS next cycle, M0_ACK two cycles after release).
- Single write then read, M0:
  - Write addr 0x0000_0010, data 0xDEADBEEF -> DM_ADDR=4, DM_WE=1 for one cycle, M0_ACK pulse, M0_ERR=0.
  - Read same address -> M0_RDATA=0xDEADBEEF with M0_ACK.
- Contention: M0 and M1 both request continuously -> grants alternate M0, M1, M0, M1. Each ACK spaced 2 cycles, no idle cycles. Each master's data lands at its own address.
- Errors:
  - M1 write addr 0x0000_1000 -> DM_WE never asserts, M1_ERR=1 with ACK.
  - M0 read addr 0x0000_0002 -> M0_ERR=1, M0_RDATA=0.
- Back-to-back on RESP: M1 raises REQ during M0's ACK cycle -> M1 enters ACCESS the next cycle. M0's still-high REQ during ACK is not re-granted.
- Reset during ACCESS of a write: DM_WE=0 after the reset edge, no ACK, state IDLE, last_grant=1.
